// File: rtl/param_lock_fsm.sv
// Digit-entry code lock with retry lockout and a two-entry code change sequence.
// All outputs registered; result pulses appear the cycle after the final digit strobe, with no backpressure.
module param_lock_fsm #(
  parameter int DIGITS      = 4,
  parameter int DW          = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCKOUT_CYC = 1000,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int FW = $clog2(MAX_TRIES + 1),
  localparam int CW = $clog2(LOCKOUT_CYC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ent,
  input  logic                 clr,
  input  logic                 change,
  input  logic [DW-1:0]        sw,
  output logic [2:0]           state_o,
  output logic [IW-1:0]        digit_idx,
  output logic [DIGITS*DW-1:0] entry_o,
  output logic [FW-1:0]        fail_cnt,
  output logic                 ok_p,
  output logic                 err_p
);

  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    OPEN     = 3'd1,
    CHG_NEW  = 3'd2,
    CHG_CONF = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [DIGITS*DW-1:0] entry_n, pw, pw_n, cand, cand_n, full;
  logic [IW-1:0]        idx_n, slot;
  logic [FW-1:0]        fail_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 ok_n, err_n, last;

  assign state_o = state;
  // The final digit is taken straight from sw so the compare needs no extra cycle.
  assign full    = {entry_o[DIGITS*DW-1:DW], sw};
  assign last    = (digit_idx == IW'(DIGITS - 1));
  assign slot    = IW'(DIGITS - 1) - digit_idx;

  always_comb begin
    state_n = state;
    entry_n = entry_o;
    idx_n   = digit_idx;
    fail_n  = fail_cnt;
    pw_n    = pw;
    cand_n  = cand;
    cnt_n   = cnt;
    ok_n    = 1'b0;
    err_n   = 1'b0;

    if (state == LOCKOUT) begin
      if (cnt == '0) begin
        state_n = LOCKED;
        fail_n  = '0;
      end else begin
        cnt_n = cnt - 1'b1;
      end
    end else if (clr) begin
      entry_n = '0;
      idx_n   = '0;
    end else if (change && state == OPEN) begin
      state_n = CHG_NEW;
      entry_n = '0;
      idx_n   = '0;
    end else if (ent) begin
      if (!last) begin
        entry_n[int'(slot)*DW +: DW] = sw;
        idx_n = digit_idx + 1'b1;
      end else begin
        entry_n = '0;
        idx_n   = '0;
        case (state)
          LOCKED: begin
            if (full == pw) begin
              state_n = OPEN;
              fail_n  = '0;
              ok_n    = 1'b1;
            end else begin
              fail_n = fail_cnt + 1'b1;
              err_n  = 1'b1;
              if (fail_cnt == FW'(MAX_TRIES - 1)) begin
                state_n = LOCKOUT;
                cnt_n   = CW'(LOCKOUT_CYC - 1);
              end
            end
          end
          OPEN: begin
            if (full == pw) begin
              state_n = LOCKED;
              ok_n    = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
          CHG_NEW: begin
            cand_n  = full;
            state_n = CHG_CONF;
          end
          CHG_CONF: begin
            state_n = OPEN;
            if (full == cand) begin
              pw_n = cand;
              ok_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
          default: state_n = LOCKED;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOCKED;
      entry_o   <= '0;
      digit_idx <= '0;
      fail_cnt  <= '0;
      pw        <= '0;
      cand      <= '0;
      cnt       <= '0;
      ok_p      <= 1'b0;
      err_p     <= 1'b0;
    end else begin
      state     <= state_n;
      entry_o   <= entry_n;
      digit_idx <= idx_n;
      fail_cnt  <= fail_n;
      pw        <= pw_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      ok_p      <= ok_n;
      err_p     <= err_n;
    end
  end

endmodule

// File: tb/tb_param_lock_fsm.sv
// Bench for param_lock_fsm: vector table, directed lockout/reset sequences, random run against a queue-based model.
module tb_param_lock_fsm;
  localparam int DIGITS = 4, DW = 4, MAX_TRIES = 3, LOCKOUT_CYC = 8;

  logic        clk = 1'b0, rst = 1'b1, ent = 1'b0, clr = 1'b0, change = 1'b0;
  logic [3:0]  sw = '0;
  logic [2:0]  state_o;
  logic [1:0]  digit_idx;
  logic [15:0] entry_o;
  logic [1:0]  fail_cnt;
  logic        ok_p, err_p;

  param_lock_fsm #(.DIGITS(DIGITS), .DW(DW), .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYC(LOCKOUT_CYC)) dut (
    .clk(clk), .rst(rst), .ent(ent), .clr(clr), .change(change), .sw(sw),
    .state_o(state_o), .digit_idx(digit_idx), .entry_o(entry_o),
    .fail_cnt(fail_cnt), .ok_p(ok_p), .err_p(err_p)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: codes as digit arrays, pending entry as a queue, lockout as cycles remaining.
  int m_state, m_fail, m_left;
  int m_pw[DIGITS], m_cand[DIGITS];
  int m_entry[$];
  bit m_ok, m_err;

  function automatic void model_reset();
    m_state = 0; m_fail = 0; m_left = 0; m_ok = 0; m_err = 0;
    for (int k = 0; k < DIGITS; k++) begin m_pw[k] = 0; m_cand[k] = 0; end
    m_entry.delete();
  endfunction

  function automatic void model_step(bit e, bit c, bit ch, int s);
    int code[DIGITS];
    bit eq_pw, eq_cand;
    m_ok = 0; m_err = 0;
    if (m_state == 4) begin
      m_left--;
      if (m_left == 0) begin m_state = 0; m_fail = 0; end
    end else if (c) begin
      m_entry.delete();
    end else if (ch && m_state == 1) begin
      m_state = 2; m_entry.delete();
    end else if (e) begin
      m_entry.push_back(s);
      if (m_entry.size() == DIGITS) begin
        eq_pw = 1; eq_cand = 1;
        for (int k = 0; k < DIGITS; k++) begin
          code[k] = m_entry[k];
          if (code[k] != m_pw[k]) eq_pw = 0;
          if (code[k] != m_cand[k]) eq_cand = 0;
        end
        m_entry.delete();
        case (m_state)
          0: if (eq_pw) begin m_state = 1; m_fail = 0; m_ok = 1; end
             else begin
               m_fail++; m_err = 1;
               if (m_fail == MAX_TRIES) begin m_state = 4; m_left = LOCKOUT_CYC; end
             end
          1: if (eq_pw) begin m_state = 0; m_ok = 1; end else m_err = 1;
          2: begin m_cand = code; m_state = 3; end
          default: begin
            if (eq_cand) begin m_pw = m_cand; m_ok = 1; end else m_err = 1;
            m_state = 1;
          end
        endcase
      end
    end
  endfunction

  function automatic int model_entry();
    int v = 0;
    for (int k = 0; k < m_entry.size(); k++) v[(DIGITS-k)*DW-1 -: DW] = m_entry[k][DW-1:0];
    return v;
  endfunction

  task automatic check_model(string tag);
    chk({tag, "_state"}, int'(state_o), m_state);
    chk({tag, "_idx"}, int'(digit_idx), m_entry.size());
    chk({tag, "_entry"}, int'(entry_o), model_entry());
    chk({tag, "_fail"}, int'(fail_cnt), m_fail);
    chk({tag, "_ok"}, int'(ok_p), int'(m_ok));
    chk({tag, "_err"}, int'(err_p), int'(m_err));
  endtask

  task automatic apply(bit e, bit c, bit ch, int s, string tag);
    @(negedge clk);
    ent = e; clr = c; change = ch; sw = 4'(s);
    @(posedge clk);
    #1;
    model_step(e, c, ch, s);
    check_model(tag);
  endtask

  task automatic do_rst(string tag);
    @(negedge clk);
    ent = 0; clr = 0; change = 0; sw = '0; rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_rst_state"}, int'(state_o), 0);
    chk({tag, "_rst_idx"}, int'(digit_idx), 0);
    chk({tag, "_rst_entry"}, int'(entry_o), 0);
    chk({tag, "_rst_fail"}, int'(fail_cnt), 0);
    chk({tag, "_rst_pulse"}, int'({ok_p, err_p}), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic enter_code(int d0, int d1, int d2, int d3, string tag);
    apply(1, 0, 0, d0, tag); apply(1, 0, 0, d1, tag);
    apply(1, 0, 0, d2, tag); apply(1, 0, 0, d3, tag);
  endtask

  typedef struct {
    bit e, c, ch;
    int sw, st, idx, entry, fail;
    bit ok, err;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit e, bit c, bit ch, int s, int st, int idx, int entry, bit ok, bit err);
    vec_t v;
    v.e = e; v.c = c; v.ch = ch; v.sw = s; v.st = st; v.idx = idx;
    v.entry = entry; v.fail = 0; v.ok = ok; v.err = err;
    tbl.push_back(v);
  endfunction

  // Four digit strobes; the first three accumulate MSB-first, the fourth resolves.
  function automatic void add_code(int d0, int d1, int d2, int d3, int st_mid, int st_end, bit ok, bit err);
    add(1, 0, 0, d0, st_mid, 1, d0 << 12, 0, 0);
    add(1, 0, 0, d1, st_mid, 2, (d0 << 12) | (d1 << 8), 0, 0);
    add(1, 0, 0, d2, st_mid, 3, (d0 << 12) | (d1 << 8) | (d2 << 4), 0, 0);
    add(1, 0, 0, d3, st_end, 0, 0, ok, err);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_rst("init");

    add_code(0, 0, 0, 0, 0, 1, 1, 0);         // default code unlocks
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);           // ok_p is one cycle
    add(1, 0, 1, 5, 2, 0, 0, 0, 0);           // change beats ent in OPEN
    add_code(1, 2, 3, 4, 2, 3, 0, 0);         // candidate
    add_code(1, 2, 3, 4, 3, 1, 1, 0);         // confirm
    add_code(1, 2, 3, 4, 1, 0, 1, 0);         // relock with new code
    add_code(1, 2, 3, 4, 0, 1, 1, 0);         // unlock with new code
    add(0, 0, 1, 0, 2, 0, 0, 0, 0);
    add_code(1, 2, 3, 4, 2, 3, 0, 0);
    add_code(1, 2, 3, 5, 3, 1, 0, 1);         // confirm mismatch
    add_code(1, 2, 3, 4, 1, 0, 1, 0);         // old code still valid
    add(0, 0, 1, 0, 0, 0, 0, 0, 0);           // change ignored when locked
    add(1, 0, 0, 2, 0, 1, 16'h2000, 0, 0);
    add(1, 0, 0, 7, 0, 2, 16'h2700, 0, 0);
    add(1, 1, 0, 9, 0, 0, 0, 0, 0);           // clr beats ent
    add(1, 0, 0, 5, 0, 1, 16'h5000, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].e, tbl[i].c, tbl[i].ch, tbl[i].sw, $sformatf("tbl%0d_model", i));
      chk($sformatf("tbl%0d_state", i), int'(state_o), tbl[i].st);
      chk($sformatf("tbl%0d_idx", i), int'(digit_idx), tbl[i].idx);
      chk($sformatf("tbl%0d_entry", i), int'(entry_o), tbl[i].entry);
      chk($sformatf("tbl%0d_fail", i), int'(fail_cnt), tbl[i].fail);
      chk($sformatf("tbl%0d_ok", i), int'(ok_p), int'(tbl[i].ok));
      chk($sformatf("tbl%0d_err", i), int'(err_p), int'(tbl[i].err));
    end

    // Lockout: three wrong codes, then exactly LOCKOUT_CYC cycles ignoring input.
    for (int t = 1; t <= MAX_TRIES; t++) begin
      enter_code(9, 9, 9, 9, "lk_wrong");
      chk($sformatf("lk_fail%0d", t), int'(fail_cnt), t);
      chk($sformatf("lk_err%0d", t), int'(err_p), 1);
      chk($sformatf("lk_state%0d", t), int'(state_o), (t == MAX_TRIES) ? 4 : 0);
    end
    for (int i = 2; i <= LOCKOUT_CYC; i++) begin
      if (i <= 5) apply(1, 0, 0, i - 1, "lk_hold");
      else apply(0, 1, 1, 0, "lk_hold");
      chk($sformatf("lk_hold_state%0d", i), int'(state_o), 4);
      chk($sformatf("lk_hold_ok%0d", i), int'(ok_p), 0);
      chk($sformatf("lk_hold_idx%0d", i), int'(digit_idx), 0);
    end
    apply(0, 0, 0, 0, "lk_exit");
    chk("lk_exit_state", int'(state_o), 0);
    chk("lk_exit_fail", int'(fail_cnt), 0);

    // Reset during lockout, then reset during confirm; both leave code 0000.
    for (int t = 0; t < MAX_TRIES; t++) enter_code(8, 8, 8, 8, "rl_wrong");
    chk("rl_in_lockout", int'(state_o), 4);
    apply(0, 0, 0, 0, "rl_idle");
    do_rst("rl");
    enter_code(0, 0, 0, 0, "rl_unlock");
    chk("rl_unlock_state", int'(state_o), 1);
    chk("rl_unlock_ok", int'(ok_p), 1);
    apply(0, 0, 1, 0, "rc_chg");
    enter_code(1, 2, 3, 4, "rc_new");
    apply(1, 0, 0, 1, "rc_part");
    chk("rc_conf_state", int'(state_o), 3);
    do_rst("rc");
    enter_code(0, 0, 0, 0, "rc_unlock");
    chk("rc_unlock_state", int'(state_o), 1);
    chk("rc_unlock_ok", int'(ok_p), 1);

    // Random run; digits mostly 0/1 so matches and lockouts occur often.
    do_rst("rnd");
    for (int i = 0; i < 3000; i++) begin
      int r, s;
      r = int'($urandom_range(0, 99));
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1));
      apply(r < 55, (r >= 55 && r < 60) || r == 99, (r >= 60 && r < 66) || r == 98, s, "rnd");
    end
    apply(0, 0, 0, 0, "rnd_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
